// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if
//   Bundles the issue/writeback/read signals of the scoreboarded register file.
//   master : decode/issue + writeback side (drives requests, reads data/busy)
//   slave  : the register file itself
//   Signals:
//     flush       re-zero all registers and busy bits
//     wr_en       writeback request, with wr_addr / wr_data
//     stall_en    blocks write and issue for this cycle
//     issue_en    reserve destination issue_addr (sets its busy bit)
//     rd_addr     packed read indices, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//     rd_data     packed read data, same packing
//     rd_busy     per-port pending-write flag of the source register
//     ready       file initialised and accepting traffic
interface reg_file_sb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
);
    logic                         flush;
    logic                         wr_en;
    logic                         stall_en;
    logic [ADDR_WIDTH-1:0]        wr_addr;
    logic [DATA_WIDTH-1:0]        wr_data;
    logic                         issue_en;
    logic [ADDR_WIDTH-1:0]        issue_addr;
    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_busy;
    logic                         ready;

    modport master (
        output flush, wr_en, stall_en, wr_addr, wr_data, issue_en, issue_addr, rd_addr,
        input  rd_data, rd_busy, ready
    );

    modport slave (
        input  flush, wr_en, stall_en, wr_addr, wr_data, issue_en, issue_addr, rd_addr,
        output rd_data, rd_busy, ready
    );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb
//   Parametrised register file with a sequential clear engine and per-register
//   busy (scoreboard) bits. After reset or flush the CLEAR state zeroes one
//   entry per cycle; traffic is accepted only in RUN (ready=1).
//   Ports:
//     clk    clock, all state updates on the rising edge
//     reset  asynchronous active-high reset
//     bus    reg_file_sb_if.slave (write, issue, combinational read ports)
//   Build option:
//     REG_FILE_BYPASS_EN  when defined, a firing write is forwarded to any
//                         read port addressing the same non-zero register in
//                         the same cycle (data and busy).
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
) (
    input  logic          clk,
    input  logic          reset,
    reg_file_sb_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] clr_idx_reg, clr_idx_next;
    logic [DEPTH-1:0]      busy_reg;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic ready;
    logic wr_fire;
    logic is_fire;

    assign ready   = (state_reg == RUN);
    assign wr_fire = ready & bus.wr_en & ~bus.stall_en & ~bus.flush & (bus.wr_addr != '0);
    assign is_fire = ready & bus.issue_en & ~bus.stall_en & ~bus.flush & (bus.issue_addr != '0);
    assign bus.ready = ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= CLEAR;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    // Next state: CLEAR walks every index once; flush restarts the walk.
    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        case (state_reg)
            CLEAR: begin
                if (bus.flush) begin
                    clr_idx_next = '0;
                end else if (&clr_idx_reg) begin
                    // last entry zeroed this cycle
                    state_next   = RUN;
                    clr_idx_next = '0;
                end else begin
                    clr_idx_next = clr_idx_reg + ADDR_WIDTH'(1);
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_next   = CLEAR;
                    clr_idx_next = '0;
                end
            end
            default: begin
                state_next   = CLEAR;
                clr_idx_next = '0;
            end
        endcase
    end

    // Storage: single write port shared by the clear engine and writeback.
    // No reset; contents become defined once CLEAR has completed.
    always_ff @(posedge clk) begin
        if (state_reg == CLEAR) begin
            mem[clr_idx_reg] <= '0;
        end else if (wr_fire) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Scoreboard: issue after write so a same-index pair leaves busy set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_reg <= '0;
        end else if (bus.flush) begin
            busy_reg <= '0;
        end else begin
            if (wr_fire) begin
                busy_reg[bus.wr_addr] <= 1'b0;
            end
            if (is_fire) begin
                busy_reg[bus.issue_addr] <= 1'b1;
            end
        end
    end

    // Combinational read ports; x0 and the whole CLEAR phase read as zero.
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] d;
        logic                  b;

        assign ra = bus.rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            d = '0;
            b = 1'b0;
            if (ready && (ra != '0)) begin
                d = mem[ra];
                b = busy_reg[ra];
`ifdef REG_FILE_BYPASS_EN
                if (wr_fire && (bus.wr_addr == ra)) begin
                    d = bus.wr_data;
                    b = is_fire && (bus.issue_addr == ra);
                end
`endif
            end
        end

        assign bus.rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = d;
        assign bus.rd_busy[gi]                          = b;
    end
endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reg_file_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2)) bus ();
    reg_file_sb_if #(.DATA_WIDTH(64), .ADDR_WIDTH(6), .NUM_RD(3)) bus_w ();

    reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    reg_file_sb #(.DATA_WIDTH(64), .ADDR_WIDTH(6), .NUM_RD(3)) dut_w (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_w.slave)
    );

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        wr_en;
        logic        stall;
        logic        issue_en;
        logic [4:0]  wa;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] wd;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        eb0;
        logic        eb1;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_main();
        bus.flush      = 1'b0;
        bus.wr_en      = 1'b0;
        bus.stall_en   = 1'b0;
        bus.issue_en   = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.issue_addr = '0;
    endtask

    task automatic idle_wide();
        bus_w.flush      = 1'b0;
        bus_w.wr_en      = 1'b0;
        bus_w.stall_en   = 1'b0;
        bus_w.issue_en   = 1'b0;
        bus_w.wr_addr    = '0;
        bus_w.wr_data    = '0;
        bus_w.issue_addr = '0;
    endtask

    // Counts edges 1..n; ready must rise exactly on edge n of each checked DUT.
    task automatic wait_clear(input string tag, input int n_main, input int n_wide);
        int n_max;
        n_max = (n_main > n_wide) ? n_main : n_wide;
        for (int k = 1; k <= n_max; k++) begin
            @(posedge clk);
            #1;
            if (k <= n_main) begin
                chk({tag, "_ready"}, 64'(bus.ready), 64'(k >= n_main));
                if (k < n_main) begin
                    chk({tag, "_clr_rd"}, 64'(bus.rd_data), 64'd0);
                    chk({tag, "_clr_busy"}, 64'(bus.rd_busy), 64'd0);
                end
            end
            if (k <= n_wide) begin
                chk({tag, "_w_ready"}, 64'(bus_w.ready), 64'(k >= n_wide));
            end
        end
        $display("txn %s: clear done after %0d/%0d cycles", tag, n_main, n_wide);
    endtask

    initial begin
        // wr_en, stall, issue_en, wa, ia, ra0, ra1, wd, e0, e1, eb0, eb1
        vecs[0] = '{1'b1, 1'b0, 1'b0, 5'd5,  5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  5'd5,  32'h00001234, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 5'd0,  5'd7,  5'd7,  5'd5,  32'h0,        32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 5'd7,  5'd0,  5'd7,  5'd7,  32'h00000055, 32'h0,        32'h0,        1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 5'd7,  5'd0,  5'd7,  5'd0,  32'h00000055, 32'h00000055, 32'h0,        1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 5'd9,  5'd9,  5'd9,  5'd7,  32'h0000000A, 32'h0000000A, 32'h00000055, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  5'd9,  32'h0,        32'h0,        32'h0000000A, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 5'd0,  5'd12, 5'd12, 5'd12, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 5'd9,  5'd0,  5'd9,  5'd9,  32'h0000000B, 32'h0000000B, 32'h0000000B, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 5'd31, 5'd0,  5'd31, 5'd1,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0};

        idle_main();
        idle_wide();
        bus.rd_addr   = {5'd0, 5'd5};
        bus_w.rd_addr = {6'd1, 6'd2, 6'd3};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(bus.ready), 64'd0);
        chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
        chk("rst_rd_busy", 64'(bus.rd_busy), 64'd0);
        chk("rst_w_ready", 64'(bus_w.ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_clear("init", 32, 64);

        // Table-driven single-cycle transactions in RUN
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.wr_en      = vecs[i].wr_en;
            bus.stall_en   = vecs[i].stall;
            bus.issue_en   = vecs[i].issue_en;
            bus.wr_addr    = vecs[i].wa;
            bus.wr_data    = vecs[i].wd;
            bus.issue_addr = vecs[i].ia;
            bus.rd_addr    = {vecs[i].ra1, vecs[i].ra0};
            @(posedge clk);
            #1;
            idle_main();
            #1;
            chk($sformatf("vec%0d_d0", i), 64'(bus.rd_data[31:0]), 64'(vecs[i].e0));
            chk($sformatf("vec%0d_d1", i), 64'(bus.rd_data[63:32]), 64'(vecs[i].e1));
            chk($sformatf("vec%0d_b0", i), 64'(bus.rd_busy[0]), 64'(vecs[i].eb0));
            chk($sformatf("vec%0d_b1", i), 64'(bus.rd_busy[1]), 64'(vecs[i].eb1));
            $display("txn vec%0d: wr=%0b st=%0b is=%0b wa=%0d ia=%0d rd=%0d/%0d -> %h/%h busy=%b",
                     i, vecs[i].wr_en, vecs[i].stall, vecs[i].issue_en, vecs[i].wa, vecs[i].ia,
                     vecs[i].ra0, vecs[i].ra1, bus.rd_data[31:0], bus.rd_data[63:32], bus.rd_busy);
        end

        // Same-cycle visibility of a write (bypass-dependent)
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd10;
        bus.wr_data = 32'h77;
        bus.rd_addr = {5'd0, 5'd10};
        #1;
        chk("byp_x10_same", 64'(bus.rd_data[31:0]), BYP ? 64'h77 : 64'h0);
        chk("byp_x10_busy", 64'(bus.rd_busy[0]), 64'd0);
        @(posedge clk);
        #1;
        idle_main();
        #1;
        chk("byp_x10_after", 64'(bus.rd_data[31:0]), 64'h77);
        $display("txn bypass x10: after edge %h", bus.rd_data[31:0]);
        @(negedge clk);
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 5'd11;
        bus.wr_data    = 32'h66;
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd11;
        bus.rd_addr    = {5'd0, 5'd11};
        #1;
        chk("byp_x11_same_d", 64'(bus.rd_data[31:0]), BYP ? 64'h66 : 64'h0);
        chk("byp_x11_same_b", 64'(bus.rd_busy[0]), BYP ? 64'd1 : 64'd0);
        @(posedge clk);
        #1;
        idle_main();
        #1;
        chk("byp_x11_after_d", 64'(bus.rd_data[31:0]), 64'h66);
        chk("byp_x11_after_b", 64'(bus.rd_busy[0]), 64'd1);
        $display("txn bypass x11: data %h busy %b", bus.rd_data[31:0], bus.rd_busy[0]);

        // Flush mid-RUN with dropped same-cycle write/issue, then write during CLEAR
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd3;
        bus.wr_data = 32'h99;
        @(negedge clk);
        idle_main();
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd20;
        bus.rd_addr    = {5'd20, 5'd3};
        @(posedge clk);
        #1;
        idle_main();
        #1;
        chk("pre_flush_x3", 64'(bus.rd_data[31:0]), 64'h99);
        chk("pre_flush_b20", 64'(bus.rd_busy[1]), 64'd1);
        @(negedge clk);
        bus.flush      = 1'b1;
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 5'd4;
        bus.wr_data    = 32'h44;
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd4;
        @(posedge clk);
        #1;
        idle_main();
        #1;
        chk("flush_ready", 64'(bus.ready), 64'd0);
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 5'd3;
        bus.wr_data    = 32'h55;
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd21;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            chk("flush_clr_ready", 64'(bus.ready), 64'd0);
            chk("flush_clr_rd", 64'(bus.rd_data), 64'd0);
        end
        idle_main();
        wait_clear("flush", 27, 0);
        bus.rd_addr = {5'd20, 5'd3};
        #1;
        chk("flush_x3", 64'(bus.rd_data[31:0]), 64'h0);
        chk("flush_b20", 64'(bus.rd_busy[1]), 64'd0);
        bus.rd_addr = {5'd21, 5'd4};
        #1;
        chk("flush_x4", 64'(bus.rd_data[31:0]), 64'h0);
        chk("flush_b4", 64'(bus.rd_busy[0]), 64'd0);
        chk("flush_b21", 64'(bus.rd_busy[1]), 64'd0);
        bus.rd_addr = {5'd0, 5'd5};
        #1;
        chk("flush_x5", 64'(bus.rd_data[31:0]), 64'h0);
        $display("txn flush: x3=%h busy=%b", bus.rd_data[31:0], bus.rd_busy);

        // Asynchronous reset at clr_idx=10 restarts the full clear
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        idle_main();
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_ready", 64'(bus.ready), 64'd0);
        chk("arst_busy", 64'(bus.rd_busy), 64'd0);
        chk("arst_w_ready", 64'(bus_w.ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_clear("arst", 32, 64);

        // Wide configuration: 64-bit data, 64 entries, three read ports
        @(negedge clk);
        bus_w.wr_en   = 1'b1;
        bus_w.wr_addr = 6'd40;
        bus_w.wr_data = 64'h1122334455667788;
        bus_w.rd_addr = {6'd40, 6'd63, 6'd40};
        @(posedge clk);
        #1;
        idle_wide();
        #1;
        chk("w_p0_x40", bus_w.rd_data[63:0], 64'h1122334455667788);
        chk("w_p1_x63", bus_w.rd_data[127:64], 64'h0);
        chk("w_p2_x40", bus_w.rd_data[191:128], 64'h1122334455667788);
        @(negedge clk);
        bus_w.wr_en      = 1'b1;
        bus_w.wr_addr    = 6'd63;
        bus_w.wr_data    = 64'hCAFEF00D12345678;
        bus_w.issue_en   = 1'b1;
        bus_w.issue_addr = 6'd40;
        @(posedge clk);
        #1;
        idle_wide();
        #1;
        chk("w_p1_x63b", bus_w.rd_data[127:64], 64'hCAFEF00D12345678);
        chk("w_busy", 64'(bus_w.rd_busy), 64'b101);
        bus_w.rd_addr = {6'd0, 6'd40, 6'd63};
        #1;
        chk("w_p0_x63", bus_w.rd_data[63:0], 64'hCAFEF00D12345678);
        chk("w_p1_x40", bus_w.rd_data[127:64], 64'h1122334455667788);
        chk("w_p2_x0", bus_w.rd_data[191:128], 64'h0);
        chk("w_busy2", 64'(bus_w.rd_busy), 64'b010);
        $display("txn wide: p0=%h p1=%h p2=%h busy=%b",
                 bus_w.rd_data[63:0], bus_w.rd_data[127:64], bus_w.rd_data[191:128], bus_w.rd_busy);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
